// File: rtl/ldpc_3gpp_enc_p3_join.sv
// Parity-3 combiner: per-stream elastic FIFOs (mm lanes, p1, acu) joined by XOR into the parity word.
// Lanes may arrive skewed; output has valid/ready backpressure, sticky errors and a frame length counter.
module ldpc_3gpp_enc_p3_join #(
  parameter int pDAT_W  = 8,
  parameter int pNCH    = 3,
  parameter int pSTRB_W = 4,
  parameter int pFIFO_W = 2,
  parameter int pPIPE   = 0,
  parameter int pCNT_W  = 16
) (
  input  logic                    iclk,
  input  logic                    ireset,
  input  logic                    iclkena,
  input  logic [pNCH-1:0]         ilane_mask,
  input  logic                    iuse_p1,
  input  logic [pNCH-1:0]         imm_val,
  input  logic [pNCH*pSTRB_W-1:0] imm_strb,
  input  logic [pNCH*pDAT_W-1:0]  imm_dat,
  input  logic                    ip1_val,
  input  logic [pDAT_W-1:0]       ip1_dat,
  input  logic                    iacu_val,
  input  logic [pSTRB_W-1:0]      iacu_strb,
  input  logic [pDAT_W-1:0]       iacu_dat,
  input  logic                    ordy,
  output logic                    oval,
  output logic [pSTRB_W-1:0]      ostrb,
  output logic [pDAT_W-1:0]       odat,
  input  logic                    iclr_err,
  output logic                    oerr_ovf,
  output logic                    oerr_strb,
  output logic [pCNT_W-1:0]       ofrm_len
);
  localparam int NF    = pNCH + 2;
  localparam int P1    = pNCH;
  localparam int ACU   = pNCH + 1;
  localparam int DEPTH = 1 << pFIFO_W;
  localparam logic [pFIFO_W:0]  PTR_ONE = 1;
  localparam logic [pCNT_W-1:0] CNT_ONE = 1;

  logic [NF-1:0]              w_raw_val,  w_in_val;
  logic [NF-1:0][pDAT_W-1:0]  w_raw_dat,  w_in_dat;
  logic [NF-1:0][pSTRB_W-1:0] w_raw_strb, w_in_strb;

  for (genvar g = 0; g < pNCH; g++) begin : g_lane
    assign w_raw_val[g]  = imm_val[g];
    assign w_raw_dat[g]  = imm_dat[g*pDAT_W +: pDAT_W];
    assign w_raw_strb[g] = imm_strb[g*pSTRB_W +: pSTRB_W];
  end
  assign w_raw_val[P1]   = ip1_val;
  assign w_raw_dat[P1]   = ip1_dat;
  assign w_raw_strb[P1]  = '0;
  assign w_raw_val[ACU]  = iacu_val;
  assign w_raw_dat[ACU]  = iacu_dat;
  assign w_raw_strb[ACU] = iacu_strb;

  if (pPIPE != 0) begin : g_pipe
    logic [NF-1:0]              r_val;
    logic [NF-1:0][pDAT_W-1:0]  r_dat;
    logic [NF-1:0][pSTRB_W-1:0] r_strb;
    always_ff @(posedge iclk) begin
      if (!ireset) begin
        r_val  <= '0;
        r_dat  <= '0;
        r_strb <= '0;
      end else if (iclkena) begin
        r_val  <= w_raw_val;
        r_dat  <= w_raw_dat;
        r_strb <= w_raw_strb;
      end
    end
    assign w_in_val  = r_val;
    assign w_in_dat  = r_dat;
    assign w_in_strb = r_strb;
  end else begin : g_nopipe
    assign w_in_val  = w_raw_val;
    assign w_in_dat  = w_raw_dat;
    assign w_in_strb = w_raw_strb;
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [NF-1:0][pFIFO_W:0] r_wptr, r_rptr;
  logic [pDAT_W-1:0]        r_mem_dat  [NF][DEPTH];
  logic [pSTRB_W-1:0]       r_mem_strb [NF][DEPTH];
  logic [pNCH-1:0]          r_mask;
  logic                     r_use_p1;
  logic                     r_oval, r_err_ovf, r_err_strb;
  logic [pSTRB_W-1:0]       r_ostrb;
  logic [pDAT_W-1:0]        r_odat;
  logic [pCNT_W-1:0]        r_cnt, r_frm_len;

  logic [NF-1:0]      w_en, w_empty, w_full, w_push_req, w_push, w_pop_f;
  logic               w_join_ok, w_pop, w_idle, w_ovf, w_strb_err;
  logic [pDAT_W-1:0]  w_xor;
  logic [pSTRB_W-1:0] w_acu_strb;
  logic [pCNT_W-1:0]  w_cnt_nxt;

  always_comb begin
    w_en       = {1'b1, r_use_p1, r_mask};
    w_empty    = '0;
    w_full     = '0;
    w_join_ok  = 1'b1;
    w_strb_err = 1'b0;
    for (int i = 0; i < NF; i++) begin
      w_empty[i] = (r_wptr[i] == r_rptr[i]);
      w_full[i]  = (r_wptr[i][pFIFO_W] != r_rptr[i][pFIFO_W]) &&
                   (r_wptr[i][pFIFO_W-1:0] == r_rptr[i][pFIFO_W-1:0]);
      if (w_en[i] && w_empty[i]) w_join_ok = 1'b0;
    end
    w_pop      = w_join_ok && (!r_oval || ordy);
    w_pop_f    = w_pop ? w_en : '0;
    w_push_req = w_in_val & w_en;
    w_push     = w_push_req & (~w_full | w_pop_f);
    w_ovf      = |(w_push_req & w_full & ~w_pop_f);
    w_idle     = (&w_empty) && !r_oval;
    w_acu_strb = r_mem_strb[ACU][r_rptr[ACU][pFIFO_W-1:0]];
    w_xor      = r_mem_dat[ACU][r_rptr[ACU][pFIFO_W-1:0]];
    if (r_use_p1) w_xor = w_xor ^ r_mem_dat[P1][r_rptr[P1][pFIFO_W-1:0]];
    for (int i = 0; i < pNCH; i++) begin
      if (r_mask[i]) begin
        w_xor = w_xor ^ r_mem_dat[i][r_rptr[i][pFIFO_W-1:0]];
        if (r_mem_strb[i][r_rptr[i][pFIFO_W-1:0]] != w_acu_strb) w_strb_err = 1'b1;
      end
    end
    w_cnt_nxt = w_acu_strb[0] ? CNT_ONE : ((&r_cnt) ? r_cnt : r_cnt + CNT_ONE);
  end

  always_ff @(posedge iclk) begin
    if (ireset && iclkena) begin
      for (int i = 0; i < NF; i++) begin
        if (w_push[i]) begin
          r_mem_dat[i][r_wptr[i][pFIFO_W-1:0]]  <= w_in_dat[i];
          r_mem_strb[i][r_wptr[i][pFIFO_W-1:0]] <= w_in_strb[i];
        end
      end
    end
  end

  always_ff @(posedge iclk) begin
    if (!ireset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_mask     <= '1;
      r_use_p1   <= 1'b1;
      r_oval     <= 1'b0;
      r_ostrb    <= '0;
      r_odat     <= '0;
      r_err_ovf  <= 1'b0;
      r_err_strb <= 1'b0;
      r_cnt      <= '0;
      r_frm_len  <= '0;
    end else if (iclkena) begin
      if (w_idle) begin
        r_mask   <= ilane_mask;
        r_use_p1 <= iuse_p1;
      end
      for (int i = 0; i < NF; i++) begin
        if (w_push[i])  r_wptr[i] <= r_wptr[i] + PTR_ONE;
        if (w_pop_f[i]) r_rptr[i] <= r_rptr[i] + PTR_ONE;
      end
      if (w_pop) begin
        r_oval  <= 1'b1;
        r_odat  <= w_xor;
        r_ostrb <= w_acu_strb;
        r_cnt   <= w_cnt_nxt;
        if (w_acu_strb[1]) r_frm_len <= w_cnt_nxt;
      end else if (ordy) begin
        r_oval <= 1'b0;
      end
      if (w_ovf)              r_err_ovf <= 1'b1;
      else if (iclr_err)      r_err_ovf <= 1'b0;
      if (w_pop && w_strb_err) r_err_strb <= 1'b1;
      else if (iclr_err)       r_err_strb <= 1'b0;
    end
  end

  assign oval      = r_oval;
  assign ostrb     = r_ostrb;
  assign odat      = r_odat;
  assign oerr_ovf  = r_err_ovf;
  assign oerr_strb = r_err_strb;
  assign ofrm_len  = r_frm_len;
endmodule

// File: tb/tb_ldpc_3gpp_enc_p3_join.sv
// Bench for ldpc_3gpp_enc_p3_join: directed scenarios plus random traffic against a queue-based
// reference model evaluated once per clock edge.
module tb_ldpc_3gpp_enc_p3_join;
  localparam int NCH = 3, DW = 8, SW = 4, DEPTH = 4;

  logic            iclk = 1'b0;
  logic            ireset, iclkena, iuse_p1, ip1_val, iacu_val, ordy, iclr_err;
  logic [NCH-1:0]  ilane_mask, imm_val;
  logic [NCH*SW-1:0] imm_strb;
  logic [NCH*DW-1:0] imm_dat;
  logic [DW-1:0]   ip1_dat, iacu_dat, odat;
  logic [SW-1:0]   iacu_strb, ostrb;
  logic            oval, oerr_ovf, oerr_strb;
  logic [15:0]     ofrm_len;

  ldpc_3gpp_enc_p3_join dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ilane_mask(ilane_mask), .iuse_p1(iuse_p1),
    .imm_val(imm_val), .imm_strb(imm_strb), .imm_dat(imm_dat), .ip1_val(ip1_val), .ip1_dat(ip1_dat),
    .iacu_val(iacu_val), .iacu_strb(iacu_strb), .iacu_dat(iacu_dat), .ordy(ordy), .oval(oval),
    .ostrb(ostrb), .odat(odat), .iclr_err(iclr_err), .oerr_ovf(oerr_ovf), .oerr_strb(oerr_strb),
    .ofrm_len(ofrm_len)
  );

  always #5 iclk = ~iclk;

  int total = 0, bad = 0;

  // Reference model: streams 0..NCH-1 are mm lanes, NCH is p1, NCH+1 is acu; entries are {strb,dat}.
  logic [11:0]    mb [NCH+2][DEPTH];
  int             mn [NCH+2];
  logic [NCH-1:0] m_mask;
  logic           m_use_p1, m_oval, m_ovf, m_serr;
  logic [7:0]     m_dat;
  logic [3:0]     m_strb;
  int unsigned    m_cnt, m_len;

  logic [7:0] fa [8], fp [8], f0 [8], f1 [8], f2 [8];
  logic [7:0] held;
  logic [3:0] s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit en [NCH+2];
    bit idle, jok, pop, ovf, serr, vld;
    logic [11:0] w;
    logic [7:0]  x;
    logic [3:0]  as;
    if (!ireset) begin
      for (int i = 0; i < NCH+2; i++) mn[i] = 0;
      m_mask = '1; m_use_p1 = 1'b1; m_oval = 1'b0; m_dat = '0; m_strb = '0;
      m_ovf = 1'b0; m_serr = 1'b0; m_cnt = 0; m_len = 0;
      return;
    end
    if (!iclkena) return;
    for (int i = 0; i < NCH; i++) en[i] = m_mask[i];
    en[NCH] = m_use_p1;
    en[NCH+1] = 1'b1;
    idle = !m_oval; jok = 1'b1; ovf = 1'b0; serr = 1'b0;
    for (int i = 0; i < NCH+2; i++) begin
      if (mn[i] != 0) idle = 1'b0;
      if (en[i] && mn[i] == 0) jok = 1'b0;
    end
    pop = jok && (!m_oval || ordy);
    if (pop) begin
      as = mb[NCH+1][0][11:8];
      x = '0;
      for (int i = 0; i < NCH+2; i++) begin
        if (en[i]) begin
          x ^= mb[i][0][7:0];
          if (i < NCH && mb[i][0][11:8] != as) serr = 1'b1;
          for (int k = 0; k < DEPTH-1; k++) mb[i][k] = mb[i][k+1];
          mn[i]--;
        end
      end
      m_dat = x; m_strb = as; m_oval = 1'b1;
      if (as[0]) m_cnt = 1;
      else if (m_cnt < 65535) m_cnt++;
      if (as[1]) m_len = m_cnt;
    end else if (ordy) begin
      m_oval = 1'b0;
    end
    for (int i = 0; i < NCH+2; i++) begin
      if (i < NCH) begin
        vld = imm_val[i]; w = {imm_strb[i*SW +: SW], imm_dat[i*DW +: DW]};
      end else if (i == NCH) begin
        vld = ip1_val; w = {4'h0, ip1_dat};
      end else begin
        vld = iacu_val; w = {iacu_strb, iacu_dat};
      end
      if (en[i] && vld) begin
        if (mn[i] < DEPTH) begin mb[i][mn[i]] = w; mn[i]++; end
        else ovf = 1'b1;
      end
    end
    if (ovf) m_ovf = 1'b1; else if (iclr_err) m_ovf = 1'b0;
    if (serr) m_serr = 1'b1; else if (iclr_err) m_serr = 1'b0;
    if (idle) begin m_mask = ilane_mask; m_use_p1 = iuse_p1; end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge iclk);
    #1;
    chk("oval", 32'(oval), 32'(m_oval));
    chk("odat", 32'(odat), 32'(m_dat));
    chk("ostrb", 32'(ostrb), 32'(m_strb));
    chk("err_ovf", 32'(oerr_ovf), 32'(m_ovf));
    chk("err_strb", 32'(oerr_strb), 32'(m_serr));
    chk("frm_len", 32'(ofrm_len), m_len);
  endtask

  task automatic set_lane(input int i, input logic v, input logic [3:0] st, input logic [7:0] d);
    imm_val[i] = v;
    imm_strb[i*SW +: SW] = st;
    imm_dat[i*DW +: DW] = d;
  endtask

  task automatic idle_in();
    imm_val = '0; ip1_val = 1'b0; iacu_val = 1'b0;
  endtask

  task automatic put_all(input logic [3:0] st, input logic [7:0] a, input logic [7:0] p,
                         input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2);
    set_lane(0, 1'b1, st, l0); set_lane(1, 1'b1, st, l1); set_lane(2, 1'b1, st, l2);
    ip1_val = 1'b1; ip1_dat = p;
    iacu_val = 1'b1; iacu_strb = st; iacu_dat = a;
  endtask

  function automatic logic [3:0] strb_of(input int k, input int last);
    return (k == 0) ? 4'h1 : ((k == last) ? 4'h2 : 4'h0);
  endfunction

  initial begin
    ireset = 1'b0; iclkena = 1'b1; ilane_mask = 3'b111; iuse_p1 = 1'b1; ordy = 1'b1; iclr_err = 1'b0;
    imm_strb = '0; imm_dat = '0; ip1_dat = '0; iacu_dat = '0; iacu_strb = '0;
    idle_in();
    cycle(); cycle();
    chk("rst_oval", 32'(oval), 0);
    chk("rst_odat", 32'(odat), 0);
    chk("rst_errs", 32'({oerr_ovf, oerr_strb}), 0);
    chk("rst_len", 32'(ofrm_len), 0);
    ireset = 1'b1;
    cycle();

    // basic XOR, aligned, single sop+eop word
    put_all(4'h3, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10);
    cycle();
    idle_in();
    chk("xor_early_oval", 32'(oval), 0);
    cycle();
    chk("xor_oval", 32'(oval), 1);
    chk("xor_odat", 32'(odat), 32'h1F);
    chk("xor_len", 32'(ofrm_len), 1);
    chk("xor_errs", 32'({oerr_ovf, oerr_strb}), 0);
    cycle(); cycle();

    // lane 2 delayed 3 cycles over an 8-word frame
    for (int k = 0; k < 8; k++) begin
      fa[k] = 8'($urandom); fp[k] = 8'($urandom);
      f0[k] = 8'($urandom); f1[k] = 8'($urandom); f2[k] = 8'($urandom);
    end
    for (int c = 0; c < 11; c++) begin
      idle_in();
      if (c < 8) begin
        s = strb_of(c, 7);
        set_lane(0, 1'b1, s, f0[c]); set_lane(1, 1'b1, s, f1[c]);
        ip1_val = 1'b1; ip1_dat = fp[c];
        iacu_val = 1'b1; iacu_strb = s; iacu_dat = fa[c];
      end
      if (c >= 3) set_lane(2, 1'b1, strb_of(c-3, 7), f2[c-3]);
      cycle();
      if (c == 3) chk("skew_early_oval", 32'(oval), 0);
      if (c == 4) begin
        chk("skew_first_oval", 32'(oval), 1);
        chk("skew_first_odat", 32'(odat), 32'(fa[0] ^ fp[0] ^ f0[0] ^ f1[0] ^ f2[0]));
      end
    end
    idle_in();
    repeat (3) cycle();
    chk("skew_len", 32'(ofrm_len), 8);
    chk("skew_ovf", 32'(oerr_ovf), 0);

    // lane mask 001 without p1, disabled streams toggle
    ilane_mask = 3'b001; iuse_p1 = 1'b0;
    cycle();
    for (int c = 0; c < 6; c++) begin
      idle_in();
      s = strb_of(c, 5);
      set_lane(0, 1'b1, s, f0[c]);
      iacu_val = 1'b1; iacu_strb = s; iacu_dat = fa[c];
      set_lane(1, 1'((c % 2) == 0), 4'hF, 8'($urandom));
      set_lane(2, 1'((c % 2) == 1), 4'hF, 8'($urandom));
      ip1_val = 1'($urandom_range(1)); ip1_dat = 8'($urandom);
      cycle();
      if (c == 1) chk("mask_odat", 32'(odat), 32'(fa[0] ^ f0[0]));
    end
    idle_in();
    repeat (3) cycle();
    chk("mask_ovf", 32'(oerr_ovf), 0);
    chk("mask_len", 32'(ofrm_len), 6);

    // backpressure: ordy low for 6 cycles under continuous input
    ilane_mask = 3'b111; iuse_p1 = 1'b1;
    cycle();
    for (int c = 0; c < 12; c++) begin
      put_all((c == 0) ? 4'h1 : 4'h0, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      ordy = !(c >= 3 && c < 9);
      if (c == 3) held = m_dat;
      cycle();
      if (c == 2) chk("bp_pre_ovf", 32'(oerr_ovf), 0);
      if (c >= 3 && c < 9) begin
        chk("bp_hold_oval", 32'(oval), 1);
        chk("bp_hold_odat", 32'(odat), 32'(held));
      end
      if (c == 8) chk("bp_ovf", 32'(oerr_ovf), 1);
    end
    idle_in(); ordy = 1'b1; iclr_err = 1'b1;
    cycle();
    iclr_err = 1'b0;
    chk("bp_clr", 32'(oerr_ovf), 0);
    repeat (8) cycle();

    // strobe mismatch on word 0 lane 1, then reset mid-frame
    for (int c = 0; c < 3; c++) begin
      s = (c == 0) ? 4'h1 : 4'h0;
      put_all(s, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      if (c == 0) imm_strb[1*SW +: SW] = 4'h0;
      cycle();
      if (c == 0) chk("strb_pre", 32'(oerr_strb), 0);
      if (c == 1) begin
        chk("strb_err", 32'(oerr_strb), 1);
        chk("strb_ostrb", 32'(ostrb), 1);
      end
    end
    idle_in(); ireset = 1'b0;
    cycle();
    chk("mrst_outs", 32'({oval, ostrb, odat}), 0);
    chk("mrst_errs", 32'({oerr_ovf, oerr_strb}), 0);
    chk("mrst_len", 32'(ofrm_len), 0);
    ireset = 1'b1;
    repeat (5) begin
      cycle();
      chk("mrst_resid", 32'(oval), 0);
    end

    // random traffic, config changes, clock enable gaps and error clears
    for (int n = 0; n < 400; n++) begin
      iclkena  = ($urandom_range(9) != 0);
      ordy     = ($urandom_range(3) != 0);
      iclr_err = ($urandom_range(19) == 0);
      if ($urandom_range(15) == 0) begin
        ilane_mask = 3'($urandom_range(7));
        iuse_p1 = 1'($urandom_range(1));
      end
      s = 4'($urandom_range(3));
      for (int i = 0; i < NCH; i++)
        set_lane(i, ($urandom_range(3) != 0), ($urandom_range(9) == 0) ? 4'($urandom_range(3)) : s,
                 8'($urandom));
      ip1_val = ($urandom_range(3) != 0); ip1_dat = 8'($urandom);
      iacu_val = ($urandom_range(3) != 0); iacu_strb = s; iacu_dat = 8'($urandom);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ldpc_3gpp_enc_p3_join.md
# ldpc_3gpp_enc_p3_join

Parametrised parity-3 combiner for the 3GPP LDPC encoder: joins up to `pNCH` T*p2 matrix-multiply product streams with the T*p1 and T*u (accumulator) streams and XORs them into the final parity word. Each input has its own elastic FIFO, so lanes with differing matrix-multiply pipeline latency need not be cycle-aligned. It also provides:
- runtime lane masking (base graph / column-count variants)
- output backpressure
- sticky overflow and strobe-mismatch flags
- a frame length counter

It sits between the matrix-multiply lanes and the output buffer.

## Interface
Parameters:
- `pDAT_W`, 8, data word width
- `pNCH`, 3, number of T*p2 matrix-multiply lanes (1..8)
- `pSTRB_W`, 4, strobe width; bit0 = sop, bit1 = eop
- `pFIFO_W`, 2, per-input FIFO address width (depth 2^pFIFO_W)
- `pPIPE`, 0, 1 = register all inputs before FIFO write
- `pCNT_W`, 16, frame word counter width

Ports:
- `iclk`  in  1  clock
- `ireset`  in  1  synchronous, active-low reset
- `iclkena`  in  1  clock enable; all state holds when low
- `ilane_mask`  in  pNCH  lane enable request
- `iuse_p1`  in  1  include p1 stream in join
- `imm_val`  in  pNCH  per-lane valid
- `imm_strb`  in  pNCH x pSTRB_W  per-lane strobe
- `imm_dat`  in  pNCH x pDAT_W  per-lane T*p2 word
- `ip1_val`  in  1  p1 valid
- `ip1_dat`  in  pDAT_W  T*p1 word
- `iacu_val`  in  1  accumulator valid
- `iacu_strb`  in  pSTRB_W  reference strobe
- `iacu_dat`  in  pDAT_W  T*u word
- `ordy`  in  1  output buffer ready
- `oval`  out  1  output valid
- `ostrb`  out  pSTRB_W  output strobe
- `odat`  out  pDAT_W  parity word
- `iclr_err`  in  1  clear sticky errors
- `oerr_ovf`  out  1  sticky FIFO overflow
- `oerr_strb`  out  1  sticky lane/acu strobe mismatch
- `ofrm_len`  out  pCNT_W  word count of last completed frame

## Operation
- **FIFOs:** one FIFO per mm lane, one for p1 and one for acu. Each stores dat; the mm-lane and acu FIFOs also store strb. All have depth 2^pFIFO_W.
- **Config latching:** `ilane_mask` and `iuse_p1` are latched into an active config in every cycle the block is idle (all FIFOs empty and `oval`=0); otherwise held. Reset config is all lanes enabled with p1 used.
- **Writes:**
  - A valid on a disabled lane (or on p1 when unused) is discarded, with no error.
  - A write to a full FIFO with no simultaneous pop drops the word and sets `oerr_ovf`.
  - Push and pop on a full FIFO in the same cycle is legal; no error.
- **Join:** `join_ok` = acu FIFO non-empty AND every enabled lane FIFO non-empty AND (p1 FIFO non-empty OR p1 unused).
- **Pop:** pop = `join_ok` AND (`oval`=0 OR `ordy`=1). Pop reads all enabled FIFOs simultaneously.
- **Output on pop:**
  - `odat` <= acu ^ p1 (if used) ^ XOR of enabled lanes; a disabled lane contributes 0.
  - `ostrb` <= acu strb; `oval` <= 1.
  - With no pop and `ordy`=1, `oval` <= 0. With `oval`=1 and `ordy`=0, the output holds.
- **Strobe check:** on pop, any enabled lane strb != acu strb sets `oerr_strb`.
- **Sticky errors:** cleared by `iclr_err`; a set in the same cycle wins.
- **Frame counter:**
  - A popped word with sop loads count=1; any other popped word increments count, saturating at 2^pCNT_W-1.
  - A popped word with eop copies the updated count to `ofrm_len`.
  - A sop+eop word gives `ofrm_len`=1.
- **Reset:** FIFOs emptied; `oval`, `ostrb`, `odat`, `oerr_ovf`, `oerr_strb`, `ofrm_len` and the internal count all 0. Reset mid-frame discards all buffered words, and no output appears until new input.
- **Clock enable:** `iclkena`=0 freezes everything. Inputs are ignored, not buffered.

## Timing
- **Latency, `pPIPE`=0:** last required input valid at cycle t -> `oval`=1 at t+2 (write at t, pop at t+1, output register). `pPIPE`=1 adds 1 cycle (t+3).
- **Throughput:** 1 word/cycle sustained while all required streams supply 1 word/cycle and `ordy`=1.
- **Stall:** `ordy`=0 with `oval`=1 holds `oval`/`ostrb`/`odat` stable. Each FIFO absorbs up to 2^pFIFO_W further words before overflow.
- **Skew tolerance:** lane skew up to 2^pFIFO_W-1 cycles is absorbed with no error and no throughput loss.
- **Config timing:** a config change takes effect on the first idle cycle after it is presented.

## Test plan
- **Basic XOR:** `pNCH`=3, all lanes, p1 used, aligned; acu=0x01, p1=0x02, lanes 0x04/0x08/0x10 at t, `ordy`=1 -> `odat`=0x1F, `oval` at t+2, no errors.
- **Skew:** lane 2 delayed 3 cycles vs others over an 8-word frame (sop word 0, eop word 7) -> 8 correct XOR outputs, first output at lane-2 arrival+2, `ofrm_len`=8, `oerr_ovf`=0.
- **Masking:** mask=3'b001, `iuse_p1`=0 latched while idle; lanes 1/2 and p1 toggle valid -> `odat`=acu^lane0, no `oerr_ovf`.
- **Backpressure/overflow:** `ordy`=0 for 6 cycles with continuous input, depth 4 -> output held, `oerr_ovf`=1 after the 6th stalled write; then `iclr_err` -> flag cleared the next cycle.
- **Strobe mismatch and reset:** lane 1 sop missing on word 0 -> `oerr_strb`=1 and `ostrb` follows acu. `ireset`=0 mid-frame -> all outputs 0 the next cycle, no residual output afterwards.
